// File: rtl/wave_capture.sv
// wave_capture
//   Capture stage feeding the waveform display renderer. Watches the audio
//   sample stream for a positive-going zero crossing. It then writes 256
//   consecutive samples into the half of a 512-entry dual-port RAM that the
//   display is not reading. When the display reports vertical blanking, it
//   swaps halves.
//
// Ports
//   clk                in   system clock
//   reset              in   synchronous, active-high reset
//   new_sample_ready   in   one-cycle strobe, new_sample_in valid
//   new_sample_in      in   signed audio sample, SAMPLE_W bits
//   wave_display_idle  in   high while the display is not scanning the waveform
//   write_address      out  RAM write address {~read_index, offset}
//   write_enable       out  RAM write strobe, one cycle per written sample
//   write_sample       out  8-bit offset-binary version of the sample
//   read_index         out  RAM half currently read by the display
//   capturing          out  high while a capture is in progress
//
// Parameters
//   SAMPLE_W      sample width, at least 8
//   TRIG_TIMEOUT  samples in ARMED before a forced trigger, 0 disables

module wave_capture #(
  parameter int SAMPLE_W     = 16,
  parameter int TRIG_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index,
  output logic                capturing
);

  localparam int TW = (TRIG_TIMEOUT < 1) ? 1 : $clog2(TRIG_TIMEOUT + 1);

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]    state;
  logic [7:0]    offset;
  logic [TW-1:0] timeout_cnt;
  // Only the sign of the previous sample matters for crossing detection,
  // so the previous-sample register keeps just that bit.
  logic          prev_sign;

  logic          sample_sign;
  logic          crossing;
  logic          timeout_hit;
  logic [7:0]    sample_byte;

  assign sample_sign = new_sample_in[SAMPLE_W-1];
  assign crossing    = prev_sign & ~sample_sign;
  // The counter holds the number of samples already seen in ARMED, so the
  // current strobe is the TRIG_TIMEOUT-th one when it equals TRIG_TIMEOUT-1.
  assign timeout_hit = (TRIG_TIMEOUT != 0) &&
                       (timeout_cnt == TW'(TRIG_TIMEOUT - 1));
  // Flipping the sign bit turns the top byte from two's complement into
  // offset binary.
  assign sample_byte = {~new_sample_in[SAMPLE_W-1],
                        new_sample_in[SAMPLE_W-2 -: 7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_ARMED;
      offset        <= 8'd0;
      timeout_cnt   <= '0;
      prev_sign     <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= 9'd0;
      write_sample  <= 8'd0;
      capturing     <= 1'b0;
    end else begin
      write_enable <= 1'b0;

      if (new_sample_ready) begin
        prev_sign <= sample_sign;
      end

      case (state)
        ST_ARMED: begin
          if (new_sample_ready) begin
            if (crossing || timeout_hit) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, 8'd0};
              write_sample  <= sample_byte;
              offset        <= 8'd1;
              timeout_cnt   <= '0;
              state         <= ST_ACTIVE;
              capturing     <= 1'b1;
            end else if (timeout_cnt != {TW{1'b1}}) begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, offset};
            write_sample  <= sample_byte;
            offset        <= offset + 8'd1;
            if (offset == 8'd255) begin
              state     <= ST_WAIT;
              capturing <= 1'b0;
            end
          end
        end

        ST_WAIT: begin
          // The swap happens only here, so the display never sees a half
          // that is still being written.
          if (wave_display_idle) begin
            read_index  <= ~read_index;
            timeout_cnt <= '0;
            state       <= ST_ARMED;
          end
        end

        default: begin
          state     <= ST_ARMED;
          capturing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture
//   Self-checking bench for wave_capture. It runs a directed sequence
//   followed by a randomized stretch. A capture-level reference model tracks
//   how many samples have been captured, which phase the capture is in, and
//   which RAM half is displayed.

module tb_wave_capture;

  localparam int SW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          new_sample_ready;
  logic [SW-1:0] new_sample_in;
  logic          wave_display_idle;
  logic [8:0]    write_address;
  logic          write_enable;
  logic [7:0]    write_sample;
  logic          read_index;
  logic          capturing;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int       m_captured;
  int       m_since;
  bit       m_trig;
  bit       m_prev_neg;
  bit       m_rindex;
  bit       e_we;
  bit       e_cap;
  bit       e_full_check;
  bit [8:0] e_addr;
  bit [7:0] e_data;

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_W(SW), .TRIG_TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .capturing         (capturing)
  );

  task automatic check_val(input string tag, input logic [8:0] got,
                           input logic [8:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic record_write(input int off, input logic [SW-1:0] s);
    e_we   = 1'b1;
    e_addr = 9'((m_rindex ? 0 : 256) + off);
    e_data = 8'(s >> 8) ^ 8'h80;
  endtask

  // The capture phase follows from the counters:
  // 256 captured samples means waiting for blanking, a trigger with fewer
  // samples means capturing, and no trigger means armed.
  task automatic model_step(input logic rst, input logic rdy,
                            input logic [SW-1:0] s, input logic idle);
    e_we         = 1'b0;
    e_full_check = 1'b0;
    if (rst) begin
      m_captured   = 0;
      m_since      = 0;
      m_trig       = 1'b0;
      m_prev_neg   = 1'b0;
      m_rindex     = 1'b0;
      e_addr       = '0;
      e_data       = '0;
      e_cap        = 1'b0;
      e_full_check = 1'b1;
      return;
    end
    if (m_captured == 256) begin
      if (idle) begin
        m_rindex   = !m_rindex;
        m_captured = 0;
        m_trig     = 1'b0;
        m_since    = 0;
      end
    end else if (m_trig) begin
      if (rdy) begin
        record_write(m_captured, s);
        m_captured++;
      end
    end else if (rdy) begin
      m_since++;
      if ((m_prev_neg && !s[SW-1]) || m_since == TO) begin
        record_write(0, s);
        m_captured = 1;
        m_trig     = 1'b1;
        m_since    = 0;
      end
    end
    if (rdy) m_prev_neg = s[SW-1];
    e_cap = m_trig && (m_captured < 256);
  endtask

  task automatic check_output();
    check_val("write_enable", 9'(write_enable), 9'(e_we));
    check_val("capturing", 9'(capturing), 9'(e_cap));
    check_val("read_index", 9'(read_index), 9'(m_rindex));
    if (e_we || e_full_check) begin
      check_val("write_address", write_address, e_addr);
      check_val("write_sample", 9'(write_sample), 9'(e_data));
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic rdy,
                                input logic [SW-1:0] s, input logic idle);
    reset             = rst;
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idle;
    @(posedge clk);
    model_step(rst, rdy, s, idle);
    #1;
    check_output();
  endtask

  initial begin
    int guard;
    int toggles;
    logic last_ri;

    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;

    // Reset state
    apply_stimulus(1, 0, 16'h0000, 0);
    apply_stimulus(1, 0, 16'h0000, 0);
    check_val("reset_address", write_address, 9'h000);

    // First crossing: the third sample triggers the capture
    apply_stimulus(0, 1, 16'h0100, 0);
    apply_stimulus(0, 1, 16'hFF00, 0);
    apply_stimulus(0, 0, 16'h0000, 0);
    apply_stimulus(0, 1, 16'h0200, 0);
    check_val("trig_address", write_address, 9'h100);
    check_val("trig_sample", 9'(write_sample), 9'h082);

    // Back-to-back ramp fills the rest of the upper half
    for (int i = 1; i < 256; i++) begin
      apply_stimulus(0, 1, 16'(i * 97), 0);
    end
    check_val("last_address", write_address, 9'h1FF);
    apply_stimulus(0, 1, 16'h1234, 0);
    check_val("wait_no_write", 9'(write_enable), 9'h000);
    check_val("wait_read_index", 9'(read_index), 9'h000);

    // Blanking swaps the halves
    apply_stimulus(0, 0, 16'h0000, 1);
    check_val("swap_read_index", 9'(read_index), 9'h001);
    apply_stimulus(0, 0, 16'h0000, 0);

    // Second capture goes into the lower half, with random strobe gaps
    apply_stimulus(0, 1, 16'h8000, 0);
    apply_stimulus(0, 1, 16'h0000, 0);
    check_val("second_trig_address", write_address, 9'h000);
    guard = 0;
    while (m_captured < 256 && guard < 3000) begin
      apply_stimulus(0, 1'($urandom_range(0, 1)), 16'($urandom), 0);
      guard++;
    end
    check_val("second_capture_done", 9'(m_captured == 256), 9'h001);
    check_val("second_capture_idle", 9'(capturing), 9'h000);

    // Forced trigger: a strobe in WAIT makes the previous sample
    // non-negative, then a constant positive input times out.
    apply_stimulus(0, 1, 16'h0100, 0);
    apply_stimulus(0, 0, 16'h0000, 1);
    for (int i = 0; i < TO - 1; i++) begin
      apply_stimulus(0, 1, 16'h1000, 0);
    end
    check_val("timeout_early", 9'(write_enable), 9'h000);
    apply_stimulus(0, 1, 16'h1000, 0);
    check_val("timeout_address", write_address, 9'h100);
    check_val("timeout_sample", 9'(write_sample), 9'h090);

    // Reset mid-capture after 100 writes
    for (int i = 1; i < 100; i++) begin
      apply_stimulus(0, 1, 16'($urandom), 0);
    end
    apply_stimulus(1, 0, 16'h0000, 0);
    check_val("midreset_capturing", 9'(capturing), 9'h000);
    apply_stimulus(0, 1, 16'h0100, 0);
    apply_stimulus(0, 1, 16'hF000, 0);
    check_val("midreset_no_write", 9'(write_enable), 9'h000);
    apply_stimulus(0, 1, 16'h0300, 0);
    check_val("midreset_retrig", write_address, 9'h100);

    // Idle held high through the capture: exactly one swap at the end
    toggles = 0;
    guard   = 0;
    last_ri = read_index;
    while (m_captured < 256 && guard < 3000) begin
      apply_stimulus(0, 1'($urandom_range(0, 1)), 16'($urandom), 1);
      if (read_index !== last_ri) toggles++;
      last_ri = read_index;
      guard++;
    end
    apply_stimulus(0, 0, 16'h0000, 1);
    if (read_index !== last_ri) toggles++;
    apply_stimulus(0, 0, 16'h0000, 0);
    check_val("held_idle_toggles", 9'(toggles), 9'h001);

    // Random traffic, with occasional blanking and rare resets
    for (int i = 0; i < 4000; i++) begin
      apply_stimulus(1'($urandom_range(0, 499) == 0),
                     1'($urandom_range(0, 1)),
                     16'($urandom),
                     1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Capture stage directly upstream of the waveform display renderer.
- Watches the audio sample stream for a positive-going zero crossing, then writes 256 consecutive samples into the half of the 512-entry dual-port sample RAM the display is not reading.
- Once the display reports it is idle (vertical blanking), swaps halves by toggling read_index.
- read_index and the RAM read port feed the display stage.

Parameters:
- SAMPLE_W, 16: width of the signed two's-complement input sample; must be at least 8.
- TRIG_TIMEOUT, 1024: number of samples accepted in ARMED without a crossing before a forced trigger; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- new_sample_ready  in  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  in  SAMPLE_W  signed audio sample.
- wave_display_idle  in  1  level; high while the display is not scanning the waveform area.
- write_address  out  9  RAM write address: {~read_index, offset[7:0]}.
- write_enable  out  1  RAM write strobe, one cycle per written sample.
- write_sample  out  8  offset-binary sample: {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}.
- read_index  out  1  half of the RAM the display reads.
- capturing  out  1  high while state == ACTIVE.

Behaviour:
- One clock domain. All outputs are registered.
- Reset values:
  - state = ARMED
  - read_index = 0, write_enable = 0, write_address = 0, write_sample = 0, capturing = 0
  - offset = 0, timeout counter = 0
  - previous-sample register = 0, which counts as non-negative.
- Previous-sample register: loads new_sample_in on every new_sample_ready, in every state, including WAIT.
- Crossing condition: prev[SAMPLE_W-1] == 1 and new_sample_in[SAMPLE_W-1] == 0, i.e. negative followed by ≥ 0.
- ARMED, on each new_sample_ready:
  - If the crossing condition holds, or TRIG_TIMEOUT != 0 and this is the TRIG_TIMEOUT-th sample since entering ARMED:
    - write this sample at offset 0
    - offset <= 1
    - clear the timeout counter
    - go to ACTIVE
  - Otherwise increment the timeout counter (saturating) and write nothing.
- ACTIVE, on each new_sample_ready:
  - write the sample at the current offset, then offset++.
  - The write at offset 255 moves the state to WAIT; offset wraps to 0.
- WAIT:
  - new_sample_ready only updates the previous-sample register; nothing is written.
  - On the first cycle with wave_display_idle == 1: read_index <= ~read_index; go to ARMED with the timeout counter cleared.
- wave_display_idle is ignored in ARMED and ACTIVE; halves never swap mid-capture.
- Write timing:
  - If new_sample_ready is high in cycle N, write_enable is high in cycle N+1 only.
  - write_address and write_sample are valid in that same cycle.
  - write_address[8] is always ~read_index as of cycle N.
- Exactly 256 writes occur between consecutive read_index toggles. Offsets run 0..255 in order with no gaps or duplicates.
- new_sample_ready asserted on consecutive cycles is legal; each strobe produces one write.
- Reset asserted in any state (including mid-ACTIVE) restores all reset values on the next edge. A partly written half is abandoned.
- capturing is registered and mirrors state == ACTIVE with no extra delay relative to the state register.

Test Plan:
- Reset, then samples 0x0100, 0xFF00, 0x0200 → no write for the first two. Write at address 0x100 with data 0x82 one cycle after the third strobe; capturing goes high.
- After trigger, 255 more strobes with ramp data → addresses 0x101..0x1FF in order, then WAIT. A 257th strobe produces no write; read_index is still 0.
- In WAIT, raise wave_display_idle for 1 cycle → read_index goes to 1 the next cycle. The next triggered capture writes addresses 0x000..0x0FF.
- TRIG_TIMEOUT=4 with a constant 0x1000 input → the 4th strobe forces a write at offset 0 with data 0x90; capture proceeds normally.
- Assert reset after 100 writes in ACTIVE → outputs return to reset values and state is ARMED; no write follows until a new crossing.
- Hold wave_display_idle high through ARMED and ACTIVE → no read_index toggle until capture completes; exactly one toggle upon entering WAIT.
